// File: rtl/dht_sensor_controller.sv
// dht_sensor_controller: single-wire DHT11/DHT22 reader. It issues the host
// start pulse, times the sensor response and 40 data bits, verifies the
// 8-bit checksum and decodes humidity/temperature. Timeouts are reported.
// An optional periodic self-trigger is available.
module dht_sensor_controller #(
  parameter int START_LOW_LONG  = 900000,
  parameter int START_LOW_SHORT = 50000,
  parameter int TIMEOUT_CYCLES  = 5000,
  parameter int BIT_THRESH      = 2000,
  parameter int AUTO_PERIOD     = 0,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  inout  wire         dht_io,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic [39:0] raw_data,
  output logic        valid,
  output logic        busy,
  output logic [1:0]  error
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_START_LOW = 4'd1;
  localparam logic [3:0] ST_WAIT_RESP = 4'd2;
  localparam logic [3:0] ST_RESP_LOW  = 4'd3;
  localparam logic [3:0] ST_RESP_HIGH = 4'd4;
  localparam logic [3:0] ST_BIT_LOW   = 4'd5;
  localparam logic [3:0] ST_BIT_HIGH  = 4'd6;
  localparam logic [3:0] ST_CHECK     = 4'd7;
  localparam logic [3:0] ST_DONE      = 4'd8;
  localparam logic [3:0] ST_FAIL      = 4'd9;

  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(START_LOW_LONG - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(START_LOW_SHORT - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] THRESH     = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam bit               AUTO_EN    = (AUTO_PERIOD != 0);
  localparam logic [CNT_W-1:0] AUTO_LAST  = AUTO_EN ? CNT_W'(AUTO_PERIOD - 1) : '0;

  logic [3:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, auto_cnt;
  logic             sync1, sync2, sync_prev;
  logic             rise, fall;
  logic [39:0]      shreg;
  logic [5:0]       bit_idx;
  logic             mode_q;
  logic             trigger, auto_fire, timeout;
  logic [CNT_W-1:0] start_last;
  logic             shift_en, bit_val, fail_en;
  logic [1:0]       fail_code;
  logic [7:0]       sum;
  logic             sum_ok;
  logic [15:0]      mag, temp_dec;

  // Open-drain: only ever pull low, otherwise release to the pull-up.
  assign dht_io = (state == ST_START_LOW) ? 1'b0 : 1'bz;
  assign busy   = (state != ST_IDLE);

  assign rise       = sync2 & ~sync_prev;
  assign fall       = ~sync2 & sync_prev;
  assign auto_fire  = AUTO_EN && (auto_cnt == AUTO_LAST);
  assign trigger    = (state == ST_IDLE) && (start || auto_fire);
  assign timeout    = (cnt == TO_LAST);
  assign start_last = mode_q ? SHORT_LAST : LONG_LAST;
  assign bit_val    = (cnt > THRESH);

  // Checksum wraps at 8 bits; carries are intentionally dropped.
  assign sum    = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
  assign sum_ok = (sum == shreg[7:0]);

  // DHT22 temperature is sign-magnitude; -0 negates to 0 naturally.
  assign mag      = {1'b0, shreg[22:16], shreg[15:8]};
  assign temp_dec = shreg[23] ? (16'd0 - mag) : mag;

  // Line synchronizer; idles high so reset cannot fake a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= dht_io;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  // Start-to-start period counter; holds at the last value while busy.
  always_ff @(posedge clk) begin
    if (rst)                        auto_cnt <= '0;
    else if (trigger)               auto_cnt <= '0;
    else if (auto_cnt != AUTO_LAST) auto_cnt <= auto_cnt + CNT_ONE;
  end

  // Next-state logic; every wait state aborts on the shared timeout.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    fail_en   = 1'b0;
    fail_code = 2'd0;
    case (state)
      ST_IDLE:      if (trigger) state_nxt = ST_START_LOW;
      ST_START_LOW: if (cnt == start_last) state_nxt = ST_WAIT_RESP;
      ST_WAIT_RESP: if (fall) state_nxt = ST_RESP_LOW;
                    else if (timeout) begin state_nxt = ST_FAIL; fail_en = 1'b1; fail_code = 2'd1; end
      ST_RESP_LOW:  if (rise) state_nxt = ST_RESP_HIGH;
                    else if (timeout) begin state_nxt = ST_FAIL; fail_en = 1'b1; fail_code = 2'd1; end
      ST_RESP_HIGH: if (fall) state_nxt = ST_BIT_LOW;
                    else if (timeout) begin state_nxt = ST_FAIL; fail_en = 1'b1; fail_code = 2'd1; end
      ST_BIT_LOW:   if (rise) state_nxt = ST_BIT_HIGH;
                    else if (timeout) begin state_nxt = ST_FAIL; fail_en = 1'b1; fail_code = 2'd1; end
      ST_BIT_HIGH: begin
        if (fall) begin
          shift_en  = 1'b1;
          state_nxt = (bit_idx == 6'd0) ? ST_CHECK : ST_BIT_LOW;
        end else if (timeout) begin
          state_nxt = ST_FAIL; fail_en = 1'b1; fail_code = 2'd1;
        end
      end
      ST_CHECK: begin
        if (sum_ok) state_nxt = ST_DONE;
        else begin state_nxt = ST_FAIL; fail_en = 1'b1; fail_code = 2'd2; end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_FAIL:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State, timing counter, frame capture and result registers.
  // Results load as DONE is entered, so valid is high for exactly the DONE
  // cycle and drops on the same edge as busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      bit_idx     <= '0;
      mode_q      <= 1'b0;
      error       <= 2'd0;
      valid       <= 1'b0;
      raw_data    <= '0;
      humidity    <= '0;
      temperature <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + CNT_ONE;
      valid <= 1'b0;
      if (trigger) begin
        mode_q <= mode;
        error  <= 2'd0;
      end
      if (fail_en) error <= fail_code;
      if (state == ST_RESP_HIGH && fall) bit_idx <= 6'd39;
      if (shift_en) begin
        shreg   <= {shreg[38:0], bit_val};
        bit_idx <= bit_idx - 6'd1;
      end
      if (state == ST_CHECK && sum_ok) begin
        raw_data    <= shreg;
        humidity    <= shreg[39:24];
        temperature <= mode_q ? temp_dec : shreg[23:8];
        valid       <= 1'b1;
      end
    end
  end

endmodule
